// File: rtl/itr_ctrl_pkg.sv
// Shared definitions for the interrupt sequencing controller: state encoding,
// default PC width and the fixed-priority source helpers.
package itr_ctrl_pkg;

    localparam int PC_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_SAVE     = 3'd2,
        ST_VECTOR   = 3'd3,
        ST_ISR      = 3'd4,
        ST_RETURN   = 3'd5
    } itr_state_e;

    // Lowest set index wins; an empty request maps to source 0.
    function automatic logic [1:0] prio_src(input logic [3:0] req);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) s = 2'(i);
        end
        return s;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/isr_watchdog.sv
// ISR watchdog: counts cycles while enabled and flags the terminal count
// (TIMEOUT-1). TIMEOUT of 0 disables the terminal flag entirely.
module isr_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic clr,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          at_tc;

    assign at_tc = (TIMEOUT != 0) && (count_q == TC_VAL);
    assign tc_o  = en_i && at_tc;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !at_tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt sequencing controller: waits for an instruction boundary, vectors
// to the ISR, guards it with a watchdog and restores the saved PC on return.
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int          PC_W        = PC_W_DEF,
    parameter int unsigned ISR_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            i_pending,
    input  logic [PC_W-1:0] isr_pc,
    input  logic [3:0]      itr_reg,
    input  logic [3:0]      mask_reg,
    input  logic [PC_W-1:0] pc_in,
    input  logic            instr_done,
    input  logic            reti,
    input  logic            ei,
    input  logic            di,
    output logic            itr_en,
    output logic            itr_clr,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_out,
    output logic            stall,
    output logic            in_isr,
    output logic [3:0]      ack,
    output logic            isr_timeout,
    output logic            bad_reti
);

    itr_state_e      state_q, state_d;
    logic            gie_q;
    logic [PC_W-1:0] saved_pc_q;
    logic [PC_W-1:0] vec_q;
    logic [1:0]      src_q;
    logic            isr_timeout_q;
    logic            bad_reti_q;
    logic            wd_tc;
    logic            req;

    // A pending request only counts while the system is enabled.
    assign req = i_pending && gie_q;

    isr_watchdog #(
        .TIMEOUT (ISR_TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .clr     (clr),
        .clear_i (state_q != ST_ISR),
        .en_i    (state_q == ST_ISR),
        .tc_o    (wd_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = instr_done ? ST_SAVE : ST_WAIT_BND;
            end
            ST_WAIT_BND: begin
                if (!req)           state_d = ST_IDLE;
                else if (instr_done) state_d = ST_SAVE;
            end
            ST_SAVE:   state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_ISR;
            ST_ISR: begin
                if (reti || wd_tc) state_d = ST_RETURN;
            end
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            gie_q         <= 1'b0;
            saved_pc_q    <= '0;
            vec_q         <= '0;
            src_q         <= '0;
            isr_timeout_q <= 1'b0;
            bad_reti_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (di)      gie_q <= 1'b0;
            else if (ei) gie_q <= 1'b1;
            if (state_q == ST_SAVE) begin
                saved_pc_q <= pc_in;
                vec_q      <= isr_pc;
                src_q      <= prio_src(itr_reg & mask_reg);
            end
            // A reti coinciding with the terminal count is a normal return.
            isr_timeout_q <= (state_q == ST_ISR) && wd_tc && !reti;
            bad_reti_q    <= reti && (state_q != ST_ISR);
        end
    end

    assign itr_en      = gie_q && (state_q == ST_IDLE || state_q == ST_WAIT_BND);
    assign itr_clr     = (state_q == ST_VECTOR);
    assign pc_load     = (state_q == ST_VECTOR) || (state_q == ST_RETURN);
    assign pc_out      = (state_q == ST_VECTOR) ? vec_q :
                         (state_q == ST_RETURN) ? saved_pc_q : '0;
    assign stall       = (state_q == ST_SAVE) || (state_q == ST_VECTOR) ||
                         (state_q == ST_RETURN);
    assign in_isr      = (state_q == ST_ISR);
    assign ack         = (state_q == ST_VECTOR) ? onehot4(src_q) : 4'b0000;
    assign isr_timeout = isr_timeout_q;
    assign bad_reti    = bad_reti_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Scoreboard bench for itr_ctrl: two instances (watchdog 0 and 4) share the
// stimulus; every expected PC load is queued with its cycle and fields.
module tb_itr_ctrl;

    logic       clk = 1'b0;
    logic       clr, i_pending, instr_done, reti, ei, di;
    logic [7:0] isr_pc, pc_in;
    logic [3:0] itr_reg, mask_reg;

    logic       a_en, a_clr, a_load, a_stall, a_isr, a_tmo, a_bad;
    logic [7:0] a_pc;
    logic [3:0] a_ack;
    logic       b_en, b_clr, b_load, b_stall, b_isr, b_tmo, b_bad;
    logic [7:0] b_pc;
    logic [3:0] b_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [7:0] pc;
        logic [3:0] ack;
        logic       iclr;
        logic       tmo;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    itr_ctrl #(.PC_W(8), .ISR_TIMEOUT(0)) dut0 (
        .clk(clk), .clr(clr), .i_pending(i_pending), .isr_pc(isr_pc),
        .itr_reg(itr_reg), .mask_reg(mask_reg), .pc_in(pc_in),
        .instr_done(instr_done), .reti(reti), .ei(ei), .di(di),
        .itr_en(a_en), .itr_clr(a_clr), .pc_load(a_load), .pc_out(a_pc),
        .stall(a_stall), .in_isr(a_isr), .ack(a_ack),
        .isr_timeout(a_tmo), .bad_reti(a_bad)
    );

    itr_ctrl #(.PC_W(8), .ISR_TIMEOUT(4)) dut4 (
        .clk(clk), .clr(clr), .i_pending(i_pending), .isr_pc(isr_pc),
        .itr_reg(itr_reg), .mask_reg(mask_reg), .pc_in(pc_in),
        .instr_done(instr_done), .reti(reti), .ei(ei), .di(di),
        .itr_en(b_en), .itr_clr(b_clr), .pc_load(b_load), .pc_out(b_pc),
        .stall(b_stall), .in_isr(b_isr), .ack(b_ack),
        .isr_timeout(b_tmo), .bad_reti(b_bad)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit to0, input bit to4, input int c, input logic [7:0] pc,
                        input logic [3:0] a, input logic ic, input logic t);
        exp_t e;
        e.c = c; e.pc = pc; e.ack = a; e.iclr = ic; e.tmo = t;
        if (to0) q0.push_back(e);
        if (to4) q4.push_back(e);
    endtask

    task automatic entry(input logic [7:0] v, input logic [7:0] p, input logic [3:0] ir,
                         input logic [3:0] mr, input logic [3:0] ea, input bit to4);
        isr_pc = v; pc_in = p; itr_reg = ir; mask_reg = mr;
        i_pending = 1'b1; instr_done = 1'b1;
        push(1'b1, to4, cyc + 2, v, ea, 1'b1, 1'b0);
        tick();
        i_pending = 1'b0; instr_done = 1'b0;
        chk("save_stall", a_stall, 1);
        tick();
        tick();
        chk("isr_in_isr", a_isr, 1);
        chk("isr_itr_en", a_en, 0);
    endtask

    task automatic ret(input logic [7:0] p, input bit to4);
        reti = 1'b1;
        push(1'b1, to4, cyc + 1, p, 4'b0000, 1'b0, 1'b0);
        tick();
        reti = 1'b0;
        chk("ret_stall", a_stall, 1);
        tick();
    endtask

    // dut0 monitor: pops on every PC load, otherwise load-only outputs stay low.
    always @(negedge clk) begin
        exp_t e;
        if (a_load) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_load", 32'(a_pc), 32'hFFFF);
            end else begin
                e = q0.pop_front();
                chk("d0_load_cyc", cyc, e.c);
                chk("d0_pc_out", a_pc, e.pc);
                chk("d0_ack", a_ack, e.ack);
                chk("d0_itr_clr", a_clr, e.iclr);
                chk("d0_isr_timeout", a_tmo, e.tmo);
            end
        end else begin
            chk("d0_idle_pc_out", {a_pc, a_ack, a_clr, a_tmo}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_load) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_load", 32'(b_pc), 32'hFFFF);
            end else begin
                e = q4.pop_front();
                chk("d4_load_cyc", cyc, e.c);
                chk("d4_pc_out", b_pc, e.pc);
                chk("d4_ack", b_ack, e.ack);
                chk("d4_itr_clr", b_clr, e.iclr);
                chk("d4_isr_timeout", b_tmo, e.tmo);
            end
        end else begin
            chk("d4_idle_pc_out", {b_pc, b_ack, b_clr, b_tmo}, 0);
        end
    end

    initial begin
        int e_cyc;
        clr = 1'b1; i_pending = 1'b0; instr_done = 1'b0; reti = 1'b0;
        ei = 1'b0; di = 1'b0; isr_pc = '0; pc_in = '0; itr_reg = '0; mask_reg = '0;
        tick(); tick();
        chk("rst_outs", {a_en, a_stall, a_isr, a_bad, a_load}, 0);
        clr = 1'b0;

        // Basic entry and return
        ei = 1'b1; tick(); ei = 1'b0;
        chk("gie_itr_en", a_en, 1);
        entry(8'hD7, 8'h42, 4'b0110, 4'b1111, 4'b0010, 1'b1);
        ret(8'h42, 1'b1);
        chk("post_ret_itr_en", a_en, 1);

        // Reset while executing an ISR
        entry(8'h10, 8'h20, 4'b1000, 4'b1111, 4'b1000, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_outs", {a_en, a_stall, a_isr, a_bad, a_tmo, a_load}, 0);
        ei = 1'b1; tick(); ei = 1'b0;
        chk("clr_to_idle", a_en, 1);

        // Withdrawn request in WAIT_BND
        i_pending = 1'b1; tick(); tick();
        chk("wait_itr_en", a_en, 1);
        i_pending = 1'b0; tick(); tick();
        chk("withdraw_stall", a_stall, 0);

        // Boundary wait then entry with masked priority
        i_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bnd_wait_stall", a_stall, 0);
        end
        entry(8'h5A, 8'h61, 4'b0101, 4'b0100, 4'b0100, 1'b1);
        ret(8'h61, 1'b1);

        // gie gating
        di = 1'b1; tick(); di = 1'b0;
        chk("di_itr_en", a_en, 0);
        i_pending = 1'b1; instr_done = 1'b1;
        tick(); tick(); tick();
        chk("gie0_no_entry", {a_stall, a_isr}, 0);
        i_pending = 1'b0; instr_done = 1'b0;
        ei = 1'b1; tick();
        chk("ei_itr_en", a_en, 1);
        di = 1'b1; tick(); ei = 1'b0; di = 1'b0;
        chk("ei_di_itr_en", a_en, 0);
        ei = 1'b1; tick(); ei = 1'b0;

        // Stray reti in IDLE
        reti = 1'b1; tick(); reti = 1'b0;
        chk("bad_reti_pulse", a_bad, 1);
        tick();
        chk("bad_reti_clear", a_bad, 0);

        // di during ISR takes effect after return
        entry(8'h80, 8'h11, 4'b0001, 4'b0001, 4'b0001, 1'b1);
        di = 1'b1; tick(); di = 1'b0;
        ret(8'h11, 1'b1);
        chk("di_in_isr_itr_en", a_en, 0);
        ei = 1'b1; tick(); ei = 1'b0;

        // Watchdog: dut4 forced return 4 cycles after ISR entry, dut0 never
        entry(8'h33, 8'h77, 4'b1010, 4'b0011, 4'b0010, 1'b1);
        e_cyc = cyc;
        push(1'b0, 1'b1, e_cyc + 4, 8'h77, 4'b0000, 1'b0, 1'b1);
        repeat (6) tick();
        chk("wd_d4_idle", b_en, 1);
        repeat (1000) tick();
        chk("wd0_still_isr", a_isr, 1);
        ret(8'h77, 1'b0);

        // Reti coincident with the terminal count
        clr = 1'b1; tick(); clr = 1'b0;
        ei = 1'b1; tick(); ei = 1'b0;
        entry(8'hC4, 8'h9E, 4'b0100, 4'b1100, 4'b0100, 1'b1);
        repeat (3) tick();
        ret(8'h9E, 1'b1);
        chk("coinc_bad_reti", b_bad, 0);

        repeat (3) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/itr_ctrl.md
# itr_ctrl

Interrupt sequencing controller for the accumulator processor. Sits between the control unit and the maskable vectored priority interrupt system: it gates that system's enable, waits for an instruction boundary, saves the return PC, redirects the PC to the ISR vector, clears the pending interrupt, holds interrupts off during the ISR, and restores the PC on return (RETI) or on ISR timeout. Nesting is not supported; one return address is held.

## Interface
Parameters:
- PC_W, 8, program counter / vector width
- ISR_TIMEOUT, 255, maximum cycles spent in ISR before forced return; 0 disables the watchdog

Ports (one clock; `clr` is a synchronous, active-high reset):
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  synchronous active-high reset
- i_pending  in  1  pending-interrupt flag from the interrupt system
- isr_pc  in  PC_W  ISR vector from the interrupt system
- itr_reg  in  4  interrupt register from the interrupt system
- mask_reg  in  4  mask register from the interrupt system
- pc_in  in  PC_W  current PC (address of next instruction)
- instr_done  in  1  one-cycle strobe at instruction boundary
- reti  in  1  RETI decoded strobe
- ei  in  1  enable-interrupts strobe
- di  in  1  disable-interrupts strobe
- itr_en  out  1  enable to the interrupt system
- itr_clr  out  1  one-cycle clear to the interrupt system
- pc_load  out  1  one-cycle PC load request
- pc_out  out  PC_W  value to load into PC when pc_load=1
- stall  out  1  holds the control unit from fetching
- in_isr  out  1  high while an ISR is executing
- ack  out  4  one-hot acknowledge of the serviced source, one cycle
- isr_timeout  out  1  one-cycle pulse on watchdog-forced return
- bad_reti  out  1  one-cycle pulse when RETI arrives outside an ISR

## Operation
- `gie` flag: reset 0; `ei` sets it and `di` clears it; `di` wins if both are asserted. Not changed by ISR entry or exit.
- itr_en = gie & (state is IDLE or WAIT_BND).
- States:
  - IDLE: i_pending & instr_done → SAVE; i_pending & !instr_done → WAIT_BND.
  - WAIT_BND: !i_pending → IDLE (interrupt masked or withdrawn); else instr_done → SAVE.
  - SAVE: stall=1. Latch saved_pc←pc_in, vec←isr_pc, src←lowest set index of (itr_reg & mask_reg); bit 0 has highest priority. → VECTOR.
  - VECTOR: stall=1, pc_load=1, pc_out=vec, itr_clr=1, ack=onehot(src). Clear the watchdog counter. → ISR.
  - ISR: in_isr=1, itr_en=0. Counter increments each cycle.
    - reti → RETURN.
    - ISR_TIMEOUT≠0 and counter reaches ISR_TIMEOUT-1 without reti → RETURN, with isr_timeout pulsed in RETURN.
  - RETURN: stall=1, pc_load=1, pc_out=saved_pc. → IDLE.
- pc_out = 0 whenever pc_load=0.
- reti in any state other than ISR is ignored, and bad_reti pulses.
- reti and timeout in the same cycle: treat as reti; no isr_timeout pulse.
- ei/di during the ISR update gie, which takes effect after RETURN.
- clr in any state → IDLE next edge. All outputs 0, gie=0, saved_pc=vec=src=counter=0.

## Timing
- Pending + instr_done sampled at edge N gives SAVE in cycle N+1, VECTOR (pc_load) in N+2, ISR from N+3.
- From IDLE, entry latency is 2 cycles after the boundary.
- Return: reti sampled in cycle M gives RETURN (pc_load) in M+1 and IDLE in M+2. itr_en reasserts in M+2 if gie=1.
- All outputs are registered-state decodes; no combinational path from inputs to outputs other than itr_en's dependence on state/gie.
- Watchdog: forced RETURN occurs exactly ISR_TIMEOUT cycles after ISR is entered.

## Structure
- Shared package: the state encoding (IDLE, WAIT_BND, SAVE, VECTOR, ISR, RETURN) and the default PC width.
- One natural sub-module: `isr_watchdog`, a resettable cycle counter with terminal-count compare, instantiated with ISR_TIMEOUT.
- FSM, gie flag, save registers and 4→2 source select live in the top.

## Test plan
- **Reset:** clr with state forced to ISR → next cycle all outputs 0, gie=0, state IDLE.
- **Entry/return:** ei; itr_reg=4'b0110, mask_reg=4'b1111, isr_pc=8'hD7, pc_in=8'h42, i_pending with instr_done.
  - Two cycles later: pc_load=1, pc_out=D7, itr_clr=1, ack=4'b0010.
  - reti → next cycle pc_load=1, pc_out=42.
- **Boundary wait:** i_pending held 3 cycles before instr_done → SAVE only after instr_done. Withdraw i_pending in WAIT_BND → return to IDLE, no pc_load.
- **gie:** gie=0 with i_pending → itr_en=0, stays IDLE. ei and di together → gie=0.
- **Watchdog:** ISR_TIMEOUT=4, no reti → pc_load with saved_pc and isr_timeout exactly 4 cycles after ISR entry. ISR_TIMEOUT=0 → no forced return after 1000 cycles.
- **Stray/ordering:** reti in IDLE → bad_reti pulse, no pc_load. reti coincident with timeout → isr_timeout stays 0.
